param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of storage entries (>=2; need not be a power of two).
REQ-003 Parameter AF_LEVEL, default 6, almost_full assertion level in entries.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty assertion level in entries.
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 CW = $clog2(DEPTH+1); the block SHALL stop elaboration unless 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read (pop) request.
REQ-011 flush  input  1  synchronous clear of contents.
REQ-012 data_in  input  WIDTH  write data.
REQ-013 data_out  output  WIDTH  read data.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 almost_full  output  1  count >= AF_LEVEL.
REQ-017 almost_empty  output  1  count <= AE_LEVEL.
REQ-018 count  output  CW  current occupancy, 0..DEPTH.
REQ-019 overflow  output  1  registered one-cycle pulse, rejected write.
REQ-020 underflow  output  1  registered one-cycle pulse, rejected read.

Function
REQ-021 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count.
REQ-022 Read accepted (rd_ok) SHALL be rd_en && !empty, evaluated on pre-edge state.
REQ-023 Write accepted (wr_ok) SHALL be wr_en && (!full || rd_ok); a simultaneous read frees the slot when full.
REQ-024 On wr_ok, data_in SHALL be stored at wr_ptr; wr_ptr SHALL advance, wrapping from DEPTH-1 to 0.
REQ-025 On rd_ok, rd_ptr SHALL advance, wrapping from DEPTH-1 to 0.
REQ-026 count SHALL become count + wr_ok - rd_ok; it never exceeds DEPTH or drops below 0.
REQ-027 wr_en && rd_en while empty: write accepted, read rejected, count +1, underflow pulses.
REQ-028 wr_en && rd_en while full: both accepted, count unchanged, no overflow.
REQ-029 overflow SHALL be 1 in the cycle after wr_en && !wr_ok, else 0.
REQ-030 underflow SHALL be 1 in the cycle after rd_en && !rd_ok, else 0.
REQ-031 FWFT=0: on rd_ok, data_out SHALL load mem[rd_ptr] at that edge (1-cycle latency); otherwise it holds.
REQ-032 FWFT=1: data_out SHALL continuously equal mem[rd_ptr], valid whenever empty=0; rd_ok pops it and the next entry appears after the edge.
REQ-033 Rejected writes and reads SHALL not modify memory, pointers, count or data_out.
REQ-034 flush=1 SHALL override wr_en/rd_en: pointers and count to 0, overflow/underflow 0 next cycle, memory untouched; FWFT=0 data_out holds.

Reset
REQ-035 reset_n low SHALL immediately clear wr_ptr, rd_ptr, count, overflow, underflow and registered data_out to 0, regardless of clk.
REQ-036 Reset asserted mid-operation SHALL discard all contents; memory array clearing is not required.
REQ-037 After reset_n deasserts, the first rising edge SHALL accept traffic.

Verification (defaults WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-038 Write 0x01..0x08 over 8 cycles, then read 8, FWFT=0 -> full=1 after 8th write; data_out 0x01..0x08 each one cycle after rd_en; empty=1 at end.
REQ-039 Fill to 8, extra write 0xAA -> overflow=1 for one cycle, count stays 8, 0xAA never read.
REQ-040 Read when empty -> underflow=1 one cycle, data_out unchanged; wr_en+rd_en when empty -> count=1, underflow=1.
REQ-041 Full, wr_en+rd_en with 0x55 for 10 cycles -> count=8 throughout, no overflow, pointers wrap, FIFO order kept.
REQ-042 Counts 0..8 -> almost_empty=1 for counts 0..2, almost_full=1 for counts 6..8.
REQ-043 FWFT=1: write 0x3C -> data_out=0x3C next cycle with no rd_en; flush with 3 entries -> count=0, empty=1 next cycle; reset_n low mid-write -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/param_fifo_if.sv
// FIFO handshake bundle: write/read requests, data and status flags.
// The slave side is the FIFO; the master side is whoever drives traffic.
interface param_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic             rd_en;
  logic             flush;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, rd_en, flush, data_in,
    input  data_out, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, flush, data_in,
    output data_out, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Single-clock synchronous FIFO, any depth >= 2, with registered or
// first-word-fall-through read and one-cycle over/underflow pulses.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic        clk,
  input logic        reset_n,
  param_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  generate
    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL
          && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("param_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_rd_ok = bus.rd_en && !w_empty;
  // A pop in the same cycle frees the slot a full FIFO is writing into.
  assign w_wr_ok = bus.wr_en && (!w_full || w_rd_ok);

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
  assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

  function automatic logic [PW-1:0] f_next(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_rd_ok) r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
      r_ovf   <= bus.wr_en && !w_wr_ok;
      r_unf   <= bus.rd_en && !w_rd_ok;
    end
  end

  // Storage has no reset; stale words are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (reset_n && !bus.flush && w_wr_ok)
      r_mem[r_wr_ptr] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          r_dout <= '0;
        else if (!bus.flush && w_rd_ok)
          r_dout <= r_mem[r_rd_ptr];
      end

      assign bus.data_out = r_dout;
    end
  endgenerate
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench: a registered-read FIFO (u_reg) and an FWFT FIFO
// (u_fwft), both at default geometry.
module tb_param_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  param_fifo_if #(.WIDTH(8), .DEPTH(8)) f0 ();
  param_fifo_if #(.WIDTH(8), .DEPTH(8)) f1 ();

  param_fifo #(
    .WIDTH(8), .DEPTH(8), .AF_LEVEL(6),
    .AE_LEVEL(2), .FWFT(0)
  ) u_reg (
    .clk(clk), .reset_n(reset_n), .bus(f0)
  );

  param_fifo #(
    .WIDTH(8), .DEPTH(8), .AF_LEVEL(6),
    .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .reset_n(reset_n), .bus(f1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt0"}, 32'(f0.count), 0);
    chk({tag, "_dout0"}, 32'(f0.data_out), 0);
    chk({tag, "_ovf0"}, 32'(f0.overflow), 0);
    chk({tag, "_unf0"}, 32'(f0.underflow), 0);
    chk({tag, "_full0"}, 32'(f0.full), 0);
    chk({tag, "_empty0"}, 32'(f0.empty), 1);
    chk({tag, "_cnt1"}, 32'(f1.count), 0);
    chk({tag, "_dout1"}, 32'(f1.data_out), 0);
    chk({tag, "_ovf1"}, 32'(f1.overflow), 0);
    chk({tag, "_empty1"}, 32'(f1.empty), 1);
  endtask

  initial begin
    f0.wr_en = 0; f0.rd_en = 0; f0.flush = 0; f0.data_in = 0;
    f1.wr_en = 0; f1.rd_en = 0; f1.flush = 0; f1.data_in = 0;
    #2;
    chk_reset("rst");
    chk("rst_ae", 32'(f0.almost_empty), 1);
    chk("rst_af", 32'(f0.almost_full), 0);
    cyc(); cyc();
    reset_n = 1'b1;

    // Fill 1..8, flags at every level
    for (int i = 1; i <= 8; i++) begin
      f0.wr_en = 1; f0.data_in = 8'(i);
      cyc();
      chk("fill_cnt", 32'(f0.count), 32'(i));
      chk("fill_ae", 32'(f0.almost_empty), 32'(i <= 2));
      chk("fill_af", 32'(f0.almost_full), 32'(i >= 6));
      chk("fill_full", 32'(f0.full), 32'(i == 8));
    end
    f0.wr_en = 0;

    for (int i = 1; i <= 8; i++) begin
      f0.rd_en = 1;
      cyc();
      chk("drain_dout", 32'(f0.data_out), 32'(i));
      chk("drain_cnt", 32'(f0.count), 32'(8 - i));
      chk("drain_ae", 32'(f0.almost_empty), 32'(8 - i <= 2));
      chk("drain_af", 32'(f0.almost_full), 32'(8 - i >= 6));
    end
    f0.rd_en = 0;
    chk("drain_empty", 32'(f0.empty), 1);

    // Overflow on full
    for (int i = 1; i <= 8; i++) begin
      f0.wr_en = 1; f0.data_in = 8'(8'h10 + i);
      cyc();
    end
    f0.data_in = 8'hAA;
    cyc();
    chk("ovf_pulse", 32'(f0.overflow), 1);
    chk("ovf_cnt", 32'(f0.count), 8);
    f0.wr_en = 0;
    cyc();
    chk("ovf_clear", 32'(f0.overflow), 0);
    chk("ovf_cnt2", 32'(f0.count), 8);

    // Simultaneous write+read while full, pointers wrap
    for (int k = 0; k < 10; k++) begin
      f0.wr_en = 1; f0.rd_en = 1;
      f0.data_in = 8'(8'h50 + k);
      cyc();
      chk("wr_full_dout", 32'(f0.data_out),
          (k < 8) ? 32'(8'h11 + k) : 32'(8'h50 + k - 8));
      chk("wr_full_cnt", 32'(f0.count), 8);
      chk("wr_full_ovf", 32'(f0.overflow), 0);
    end
    f0.wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      f0.rd_en = 1;
      cyc();
      chk("wrap_dout", 32'(f0.data_out), 32'(8'h52 + i));
      chk("wrap_cnt", 32'(f0.count), 32'(7 - i));
    end

    // Underflow and empty write+read
    cyc();
    chk("unf_pulse", 32'(f0.underflow), 1);
    chk("unf_dout", 32'(f0.data_out), 32'h59);
    chk("unf_cnt", 32'(f0.count), 0);
    f0.rd_en = 0;
    cyc();
    chk("unf_clear", 32'(f0.underflow), 0);
    f0.wr_en = 1; f0.rd_en = 1; f0.data_in = 8'h77;
    cyc();
    chk("wrrd_empty_cnt", 32'(f0.count), 1);
    chk("wrrd_empty_unf", 32'(f0.underflow), 1);
    chk("wrrd_empty_dout", 32'(f0.data_out), 32'h59);
    f0.wr_en = 0; f0.rd_en = 0;

    // Flush overrides a write; registered data_out holds
    f0.flush = 1; f0.wr_en = 1; f0.data_in = 8'h99;
    cyc();
    f0.flush = 0; f0.wr_en = 0;
    chk("flush0_cnt", 32'(f0.count), 0);
    chk("flush0_empty", 32'(f0.empty), 1);
    chk("flush0_dout", 32'(f0.data_out), 32'h59);

    // FWFT mode
    f1.wr_en = 1; f1.data_in = 8'h3C;
    cyc();
    f1.wr_en = 0;
    chk("fwft_dout", 32'(f1.data_out), 32'h3C);
    chk("fwft_cnt", 32'(f1.count), 1);
    f1.wr_en = 1; f1.data_in = 8'h3D;
    cyc();
    f1.data_in = 8'h3E;
    cyc();
    f1.wr_en = 0;
    chk("fwft_hold", 32'(f1.data_out), 32'h3C);
    chk("fwft_cnt3", 32'(f1.count), 3);
    f1.rd_en = 1;
    cyc();
    f1.rd_en = 0;
    chk("fwft_pop", 32'(f1.data_out), 32'h3D);
    chk("fwft_cnt2", 32'(f1.count), 2);
    f1.wr_en = 1; f1.data_in = 8'h40;
    cyc();
    f1.wr_en = 0;
    chk("fwft_cnt3b", 32'(f1.count), 3);
    f1.flush = 1;
    cyc();
    f1.flush = 0;
    chk("fwft_flush_cnt", 32'(f1.count), 0);
    chk("fwft_flush_empty", 32'(f1.empty), 1);

    // Asynchronous reset in the middle of a write burst
    f1.wr_en = 1; f1.data_in = 8'h81;
    f0.wr_en = 1; f0.data_in = 8'h82;
    cyc();
    chk("pre_rst_cnt1", 32'(f1.count), 1);
    chk("pre_rst_dout1", 32'(f1.data_out), 32'h81);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset("arst");
    f0.wr_en = 0; f1.wr_en = 0;
    cyc();
    reset_n = 1'b1;
    f1.wr_en = 1; f1.data_in = 8'h5A;
    cyc();
    f1.wr_en = 0;
    chk("post_rst_cnt", 32'(f1.count), 1);
    chk("post_rst_dout", 32'(f1.data_out), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
